// File: rtl/spi_regfile_pkg.sv
// Shared types and helpers for the SPI register-file target.
package spi_regfile_pkg;

    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} spi_fsm_t;

    localparam logic RW_WRITE = 1'b1;

    function automatic int frame_len(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous SPI pin, with rise/fall pulses
// aligned to the synchronised level.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES:0] r_pipe;
    logic [STAGES:0] r_valid;

    // Edges stay masked until the pipe holds only post-reset samples, so a pin
    // that differs from RST_VAL when reset releases does not fake an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe  <= {(STAGES + 1){RST_VAL}};
            r_valid <= '0;
        end else begin
            r_pipe  <= {r_pipe[STAGES-1:0], i_async};
            r_valid <= {r_valid[STAGES-1:0], 1'b1};
        end
    end

    assign o_level = r_pipe[STAGES-1];
    assign o_rise  = r_valid[STAGES] & r_pipe[STAGES-1] & ~r_pipe[STAGES];
    assign o_fall  = r_valid[STAGES] & ~r_pipe[STAGES-1] & r_pipe[STAGES];

endmodule

// File: rtl/spi_regfile_peripheral.sv
// SPI target with a parametrised register bank; all four SPI modes.
// Build option: SPI_READBACK_EN enables register readback on MISO.
//
// state | meaning
// IDLE  | waiting for a cs falling edge
// CMD   | sampling R/W bit and address
// DATA  | sampling write data / shifting read data out
// DONE  | frame complete; commit write, wait for cs rise
module spi_regfile_peripheral
    import spi_regfile_pkg::*;
#(
    parameter int NUM_REGS    = 5,
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 7,
    parameter bit SPI_CPOL    = 1'b0,
    parameter bit SPI_CPHA    = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         spi_sclk,
    input  logic                         spi_cs,
    input  logic                         spi_mosi,
    output logic                         spi_miso,
    output logic                         spi_miso_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
    output logic [NUM_REGS-1:0]          wr_strobe,
    output logic                         frame_err
);

    localparam int FRAME_LEN = frame_len(ADDR_W, DATA_W);
    localparam int CNT_W     = $clog2(FRAME_LEN);

    logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
    logic w_cs_lvl, w_cs_rise, w_cs_fall;
    logic w_mosi, w_mosi_rise, w_mosi_fall;
    logic w_unused_sync;
    logic w_sample;
    logic [ADDR_W:0] w_cmd_next;

    spi_fsm_t                   r_state;
    logic [CNT_W-1:0]           r_cnt;
    logic [ADDR_W-1:0]          r_cmd;
    logic [ADDR_W-1:0]          r_addr;
    logic [DATA_W-1:0]          r_data;
    logic                       r_write;
    logic                       r_err_seen;
    logic                       r_frame_err;
    logic [NUM_REGS-1:0]        r_wr_strobe;
    logic [NUM_REGS*DATA_W-1:0] r_regs;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(SPI_CPOL)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .i_async(spi_sclk),
        .o_level(w_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .i_async(spi_cs),
        .o_level(w_cs_lvl), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .i_async(spi_mosi),
        .o_level(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );

    assign w_unused_sync = &{w_sclk_lvl, w_cs_lvl, w_mosi_rise, w_mosi_fall};

    assign w_sample   = (SPI_CPOL == SPI_CPHA) ? w_sclk_rise : w_sclk_fall;
    assign w_cmd_next = {r_cmd, w_mosi};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_cmd       <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_write     <= 1'b0;
            r_err_seen  <= 1'b0;
            r_frame_err <= 1'b0;
            r_wr_strobe <= '0;
            r_regs      <= '0;
        end else begin
            r_frame_err <= 1'b0;
            r_wr_strobe <= '0;
            case (r_state)
                IDLE: begin
                    if (w_cs_fall) begin
                        r_state    <= CMD;
                        r_cnt      <= CNT_W'(ADDR_W);
                        r_cmd      <= '0;
                        r_data     <= '0;
                        r_write    <= 1'b0;
                        r_err_seen <= 1'b0;
                    end
                end
                CMD: begin
                    if (w_cs_rise) begin
                        r_state     <= IDLE;
                        r_frame_err <= 1'b1;
                    end else if (w_sample) begin
                        r_cmd <= w_cmd_next[ADDR_W-1:0];
                        if (r_cnt == '0) begin
                            r_state <= DATA;
                            r_cnt   <= CNT_W'(DATA_W - 1);
                            r_write <= (w_cmd_next[ADDR_W] == RW_WRITE);
                            r_addr  <= w_cmd_next[ADDR_W-1:0];
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (w_cs_rise) begin
                        r_state     <= IDLE;
                        r_frame_err <= 1'b1;
                    end else if (w_sample) begin
                        r_data <= (r_data << 1) | DATA_W'(w_mosi);
                        if (r_cnt == '0) r_state <= DONE;
                        else             r_cnt   <= r_cnt - 1'b1;
                    end
                end
                DONE: begin
                    // Out-of-range addresses match no index, so the write drops silently.
                    if (r_write) begin
                        r_write <= 1'b0;
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (r_addr == ADDR_W'(i)) begin
                                r_regs[i*DATA_W +: DATA_W] <= r_data;
                                r_wr_strobe[i]             <= 1'b1;
                            end
                        end
                    end
                    if (w_cs_rise) begin
                        r_state <= IDLE;
                    end else if (w_sample && !r_err_seen) begin
                        r_frame_err <= 1'b1;
                        r_err_seen  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign regs_flat = r_regs;
    assign wr_strobe = r_wr_strobe;
    assign frame_err = r_frame_err;

`ifdef SPI_READBACK_EN
    logic              w_shift;
    logic [DATA_W-1:0] w_rd_data;
    logic [DATA_W-1:0] r_shift_out;
    logic              r_miso;

    assign w_shift = (SPI_CPOL == SPI_CPHA) ? w_sclk_fall : w_sclk_rise;

    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_cmd_next[ADDR_W-1:0] == ADDR_W'(i)) w_rd_data = r_regs[i*DATA_W +: DATA_W];
        end
    end

    // Every DATA-state shift edge presents the next bit, which covers both CPHA
    // cases: for CPHA=0 the first one is the trailing edge of the last address bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift_out <= '0;
            r_miso      <= 1'b0;
        end else if (r_state == CMD && w_sample && !w_cs_rise && r_cnt == '0) begin
            r_shift_out <= (w_cmd_next[ADDR_W] == RW_WRITE) ? '0 : w_rd_data;
            r_miso      <= 1'b0;
        end else if (r_state == DATA && !r_write && !w_cs_rise) begin
            if (w_shift) begin
                r_miso      <= r_shift_out[DATA_W-1];
                r_shift_out <= r_shift_out << 1;
            end
        end else begin
            r_miso <= 1'b0;
        end
    end

    assign spi_miso    = r_miso;
    assign spi_miso_oe = ~w_cs_lvl;
`else
    assign spi_miso    = 1'b1;
    assign spi_miso_oe = 1'b0;
`endif

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Directed bench: mode 0/1/2/3 instances with 5x8 registers plus one mode-0 8x16 instance.
module tb_spi_regfile_peripheral;

    localparam int HP = 60;
`ifdef SPI_READBACK_EN
    localparam bit RB_EN = 1'b1;
`else
    localparam bit RB_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        sclk_ph;
    logic        mosi;
    logic [4:0]  cs_n;
    logic [4:0]  sclk_v;
    logic [4:0]  miso_v;
    logic [4:0]  oe_v;
    logic [4:0]  ferr_v;
    logic [39:0] regs_n [4];
    logic [4:0]  strb_n [4];
    logic [127:0] regs_w;
    logic [7:0]  strb_w;
    logic [7:0]  strb_any [5];

    int n_cmp;
    int n_fail;
    int strb_cyc [5];
    int ferr_cyc [5];
    logic [7:0] strb_last [5];

    assign sclk_v = {sclk_ph, ~sclk_ph, ~sclk_ph, sclk_ph, sclk_ph};

    spi_regfile_peripheral u_m0 (
        .clk(clk), .rst_n(rst_n), .spi_sclk(sclk_v[0]), .spi_cs(cs_n[0]), .spi_mosi(mosi),
        .spi_miso(miso_v[0]), .spi_miso_oe(oe_v[0]), .regs_flat(regs_n[0]),
        .wr_strobe(strb_n[0]), .frame_err(ferr_v[0])
    );
    spi_regfile_peripheral #(.SPI_CPOL(1'b0), .SPI_CPHA(1'b1)) u_m1 (
        .clk(clk), .rst_n(rst_n), .spi_sclk(sclk_v[1]), .spi_cs(cs_n[1]), .spi_mosi(mosi),
        .spi_miso(miso_v[1]), .spi_miso_oe(oe_v[1]), .regs_flat(regs_n[1]),
        .wr_strobe(strb_n[1]), .frame_err(ferr_v[1])
    );
    spi_regfile_peripheral #(.SPI_CPOL(1'b1), .SPI_CPHA(1'b0)) u_m2 (
        .clk(clk), .rst_n(rst_n), .spi_sclk(sclk_v[2]), .spi_cs(cs_n[2]), .spi_mosi(mosi),
        .spi_miso(miso_v[2]), .spi_miso_oe(oe_v[2]), .regs_flat(regs_n[2]),
        .wr_strobe(strb_n[2]), .frame_err(ferr_v[2])
    );
    spi_regfile_peripheral #(.SPI_CPOL(1'b1), .SPI_CPHA(1'b1)) u_m3 (
        .clk(clk), .rst_n(rst_n), .spi_sclk(sclk_v[3]), .spi_cs(cs_n[3]), .spi_mosi(mosi),
        .spi_miso(miso_v[3]), .spi_miso_oe(oe_v[3]), .regs_flat(regs_n[3]),
        .wr_strobe(strb_n[3]), .frame_err(ferr_v[3])
    );
    spi_regfile_peripheral #(.NUM_REGS(8), .DATA_W(16)) u_w16 (
        .clk(clk), .rst_n(rst_n), .spi_sclk(sclk_v[4]), .spi_cs(cs_n[4]), .spi_mosi(mosi),
        .spi_miso(miso_v[4]), .spi_miso_oe(oe_v[4]), .regs_flat(regs_w),
        .wr_strobe(strb_w), .frame_err(ferr_v[4])
    );

    assign strb_any[0] = {3'b000, strb_n[0]};
    assign strb_any[1] = {3'b000, strb_n[1]};
    assign strb_any[2] = {3'b000, strb_n[2]};
    assign strb_any[3] = {3'b000, strb_n[3]};
    assign strb_any[4] = strb_w;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        for (int k = 0; k < 5; k++) begin
            if (strb_any[k] != 8'h00) begin
                strb_cyc[k]++;
                strb_last[k] = strb_any[k];
            end
            if (ferr_v[k]) ferr_cyc[k]++;
        end
    end

    task automatic spi_frame(input int inst, input int nbits, input logic [31:0] word,
                             input int ncyc, output logic [31:0] rx);
        logic b;
        logic cpha;
        cpha = (inst == 1) || (inst == 3);
        rx = '0;
        cs_n[inst] = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            b = (i < nbits) ? word[nbits-1-i] : 1'b0;
            if (!cpha) mosi = b;
            #(HP);
            if (!cpha) rx = {rx[30:0], miso_v[inst]};
            sclk_ph = 1'b1;
            if (cpha) mosi = b;
            #(HP);
            if (cpha) rx = {rx[30:0], miso_v[inst]};
            sclk_ph = 1'b0;
        end
        #(HP);
        cs_n[inst] = 1'b1;
        mosi = 1'b0;
        #(4 * HP);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #(25);
        n_cmp++; if (regs_n[0] !== 40'h0) begin n_fail++; $display("FAIL reset_regs0 got=%h exp=0", regs_n[0]); end
        n_cmp++; if (regs_w !== 128'h0) begin n_fail++; $display("FAIL reset_regs_w got=%h exp=0", regs_w); end
        n_cmp++; if (strb_n[0] !== 5'h0) begin n_fail++; $display("FAIL reset_strobe got=%b exp=0", strb_n[0]); end
        n_cmp++; if (ferr_v !== 5'h0) begin n_fail++; $display("FAIL reset_frame_err got=%b exp=0", ferr_v); end
        n_cmp++; if (oe_v !== 5'h0) begin n_fail++; $display("FAIL reset_oe got=%b exp=0", oe_v); end
        n_cmp++; if (miso_v !== (RB_EN ? 5'b00000 : 5'b11111)) begin
            n_fail++; $display("FAIL reset_miso got=%b exp=%b", miso_v, (RB_EN ? 5'b00000 : 5'b11111));
        end
        rst_n = 1'b1;
        #(40);
    endtask

    task automatic test_mode0_write();
        logic [31:0] rx;
        int s0, f0;
        s0 = strb_cyc[0]; f0 = ferr_cyc[0];
        spi_frame(0, 16, 32'h82A5, 16, rx);
        n_cmp++; if (regs_n[0] !== 40'h0000A50000) begin n_fail++; $display("FAIL m0_write_regs got=%h exp=0000a50000", regs_n[0]); end
        n_cmp++; if (strb_cyc[0] - s0 !== 1) begin n_fail++; $display("FAIL m0_strobe_cycles got=%0d exp=1", strb_cyc[0] - s0); end
        n_cmp++; if (strb_last[0] !== 8'h04) begin n_fail++; $display("FAIL m0_strobe_bits got=%b exp=00000100", strb_last[0]); end
        n_cmp++; if (ferr_cyc[0] - f0 !== 0) begin n_fail++; $display("FAIL m0_no_err got=%0d exp=0", ferr_cyc[0] - f0); end
    endtask

    task automatic test_modes();
        logic [31:0] rx;
        int s0;
        for (int m = 1; m <= 3; m++) begin
            s0 = strb_cyc[m];
            spi_frame(m, 16, 32'h843C, 16, rx);
            n_cmp++; if (regs_n[m] !== 40'h3C00000000) begin n_fail++; $display("FAIL mode%0d_write got=%h exp=3c00000000", m, regs_n[m]); end
            n_cmp++; if (strb_last[m] !== 8'h10) begin n_fail++; $display("FAIL mode%0d_strobe got=%b exp=00010000", m, strb_last[m]); end
            spi_frame(m, 16, 32'h0400, 16, rx);
            n_cmp++; if (rx[7:0] !== (RB_EN ? 8'h3C : 8'hFF)) begin
                n_fail++; $display("FAIL mode%0d_read got=%h exp=%h", m, rx[7:0], (RB_EN ? 8'h3C : 8'hFF));
            end
            n_cmp++; if (strb_cyc[m] - s0 !== 1) begin n_fail++; $display("FAIL mode%0d_strobe_count got=%0d exp=1", m, strb_cyc[m] - s0); end
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rx;
        int s0, f0;
        s0 = strb_cyc[0]; f0 = ferr_cyc[0];
        spi_frame(0, 16, 32'h0000, 16, rx);
        n_cmp++; if (rx[7:0] !== (RB_EN ? 8'h00 : 8'hFF)) begin n_fail++; $display("FAIL read_addr0 got=%h exp=%h", rx[7:0], (RB_EN ? 8'h00 : 8'hFF)); end
        spi_frame(0, 16, 32'h89FF, 16, rx);
        n_cmp++; if (strb_cyc[0] - s0 !== 0) begin n_fail++; $display("FAIL oor_write_strobe got=%0d exp=0", strb_cyc[0] - s0); end
        n_cmp++; if (regs_n[0] !== 40'h0000A50000) begin n_fail++; $display("FAIL oor_write_regs got=%h exp=0000a50000", regs_n[0]); end
        spi_frame(0, 16, 32'h0900, 16, rx);
        n_cmp++; if (rx[7:0] !== (RB_EN ? 8'h00 : 8'hFF)) begin n_fail++; $display("FAIL oor_read got=%h exp=%h", rx[7:0], (RB_EN ? 8'h00 : 8'hFF)); end
        n_cmp++; if (ferr_cyc[0] - f0 !== 0) begin n_fail++; $display("FAIL oor_no_err got=%0d exp=0", ferr_cyc[0] - f0); end
    endtask

    task automatic test_abort();
        logic [31:0] rx;
        int s0, f0;
        s0 = strb_cyc[0]; f0 = ferr_cyc[0];
        spi_frame(0, 16, 32'h8177, 10, rx);
        n_cmp++; if (regs_n[0] !== 40'h0000A50000) begin n_fail++; $display("FAIL abort_regs got=%h exp=0000a50000", regs_n[0]); end
        n_cmp++; if (ferr_cyc[0] - f0 !== 1) begin n_fail++; $display("FAIL abort_err_pulse got=%0d exp=1", ferr_cyc[0] - f0); end
        n_cmp++; if (strb_cyc[0] - s0 !== 0) begin n_fail++; $display("FAIL abort_strobe got=%0d exp=0", strb_cyc[0] - s0); end
    endtask

    task automatic test_oversize();
        logic [31:0] rx;
        int s0, f0;
        s0 = strb_cyc[0]; f0 = ferr_cyc[0];
        spi_frame(0, 16, 32'h8312, 18, rx);
        n_cmp++; if (regs_n[0] !== 40'h0012A50000) begin n_fail++; $display("FAIL oversize_regs got=%h exp=0012a50000", regs_n[0]); end
        n_cmp++; if (ferr_cyc[0] - f0 !== 1) begin n_fail++; $display("FAIL oversize_err_pulse got=%0d exp=1", ferr_cyc[0] - f0); end
        n_cmp++; if (strb_cyc[0] - s0 !== 1) begin n_fail++; $display("FAIL oversize_strobe got=%0d exp=1", strb_cyc[0] - s0); end
        n_cmp++; if (strb_last[0] !== 8'h08) begin n_fail++; $display("FAIL oversize_strobe_bits got=%b exp=00001000", strb_last[0]); end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] rx;
        int s0, f0;
        s0 = strb_cyc[0]; f0 = ferr_cyc[0];
        fork
            spi_frame(0, 16, 32'h8155, 16, rx);
            begin
                #(12 * HP);
                rst_n = 1'b0;
                #(50);
                rst_n = 1'b1;
            end
        join
        n_cmp++; if (regs_n[0] !== 40'h0) begin n_fail++; $display("FAIL midrst_regs0 got=%h exp=0", regs_n[0]); end
        n_cmp++; if (regs_n[1] !== 40'h0) begin n_fail++; $display("FAIL midrst_regs1 got=%h exp=0", regs_n[1]); end
        n_cmp++; if (strb_cyc[0] - s0 !== 0) begin n_fail++; $display("FAIL midrst_strobe got=%0d exp=0", strb_cyc[0] - s0); end
        n_cmp++; if (ferr_cyc[0] - f0 !== 0) begin n_fail++; $display("FAIL midrst_err got=%0d exp=0", ferr_cyc[0] - f0); end
        spi_frame(0, 16, 32'h805A, 16, rx);
        n_cmp++; if (regs_n[0] !== 40'h000000005A) begin n_fail++; $display("FAIL midrst_rewrite got=%h exp=000000005a", regs_n[0]); end
        n_cmp++; if (strb_cyc[0] - s0 !== 1) begin n_fail++; $display("FAIL midrst_rewrite_strobe got=%0d exp=1", strb_cyc[0] - s0); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rx;
        int s0;
        s0 = strb_cyc[0];
        spi_frame(0, 16, 32'h8011, 16, rx);
        spi_frame(0, 16, 32'h8144, 16, rx);
        n_cmp++; if (regs_n[0] !== 40'h0000004411) begin n_fail++; $display("FAIL b2b_regs got=%h exp=0000004411", regs_n[0]); end
        n_cmp++; if (strb_cyc[0] - s0 !== 2) begin n_fail++; $display("FAIL b2b_strobes got=%0d exp=2", strb_cyc[0] - s0); end
        n_cmp++; if (strb_last[0] !== 8'h02) begin n_fail++; $display("FAIL b2b_last_strobe got=%b exp=00000010", strb_last[0]); end
    endtask

    task automatic test_wide();
        logic [31:0] rx;
        int s0;
        s0 = strb_cyc[4];
        spi_frame(4, 24, 32'h0087BEEF, 24, rx);
        n_cmp++; if (regs_w[127:112] !== 16'hBEEF) begin n_fail++; $display("FAIL wide_reg7 got=%h exp=beef", regs_w[127:112]); end
        n_cmp++; if (regs_w[111:0] !== 112'h0) begin n_fail++; $display("FAIL wide_others got=%h exp=0", regs_w[111:0]); end
        n_cmp++; if (strb_cyc[4] - s0 !== 1) begin n_fail++; $display("FAIL wide_strobe_count got=%0d exp=1", strb_cyc[4] - s0); end
        n_cmp++; if (strb_last[4] !== 8'h80) begin n_fail++; $display("FAIL wide_strobe_bits got=%b exp=10000000", strb_last[4]); end
        spi_frame(4, 24, 32'h00070000, 24, rx);
        n_cmp++; if (rx[15:0] !== (RB_EN ? 16'hBEEF : 16'hFFFF)) begin
            n_fail++; $display("FAIL wide_read got=%h exp=%h", rx[15:0], (RB_EN ? 16'hBEEF : 16'hFFFF));
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_fail  = 0;
        for (int k = 0; k < 5; k++) begin
            strb_cyc[k]  = 0;
            ferr_cyc[k]  = 0;
            strb_last[k] = 8'h00;
        end
        rst_n   = 1'b0;
        sclk_ph = 1'b0;
        mosi    = 1'b0;
        cs_n    = 5'b11111;

        test_reset();
        test_mode0_write();
        test_modes();
        test_out_of_range();
        test_abort();
        test_oversize();
        test_reset_midframe();
        test_back_to_back();
        test_wide();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
